// File: rtl/arq_pkg.sv
// Shared encodings for the ACL TX ARQ source engine.
// Decision kinds, FSM states and LT index width.
package arq_pkg;

    localparam int LT_W = 3;

    typedef enum logic [1:0] {
        KIND_NULL = 2'd0,
        KIND_NEW  = 2'd1,
        KIND_OLD  = 2'd2,
        KIND_ZERO = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACKCHK = 2'd1,
        ST_DECIDE = 2'd2
    } state_e;

endpackage

// File: rtl/acltx_ltstate.sv
// Per-LT ARQ slice: ping-pong buffer occupancy, SEQN, wait/flush flags.
// Retransmit counter exists only when ARQ_AUTOFLUSH_EN is defined.
module acltx_ltstate
    import arq_pkg::*;
#(
    parameter int LEN_W = 10
`ifdef ARQ_AUTOFLUSH_EN
   ,parameter int RETX_MAX = 15
`endif
) (
    input  logic             clk_6M,
    input  logic             rstz,
    input  logic             i_init,
    input  logic             i_ack,
    input  logic             i_dec,
    input  kind_e            i_kind,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_load_len,
    input  logic             i_flush,
    output logic             o_act_v,
    output logic             o_pend_v,
    output logic             o_act_sel,
    output logic             o_seqn,
    output logic             o_wait_ack,
    output logic             o_flush_f,
    output logic             o_full,
    output logic [LEN_W-1:0] o_len_act
);

    logic             r_act_v, r_pend_v, r_sel, r_seqn, r_wait, r_flush;
    logic [LEN_W-1:0] r_len [2];
    logic             w_act_v, w_pend_v, w_sel, w_seqn, w_wait, w_flush;
    logic             w_full;
    logic [LEN_W-1:0] w_len [2];
`ifdef ARQ_AUTOFLUSH_EN
    logic [3:0]       r_retx, w_retx;
`endif

    // Next state: ack/decide release first, then load sees the freed slot.
    always_comb begin
        w_act_v  = r_act_v;
        w_pend_v = r_pend_v;
        w_sel    = r_sel;
        w_seqn   = r_seqn;
        w_wait   = r_wait;
        w_flush  = r_flush;
        w_len[0] = r_len[0];
        w_len[1] = r_len[1];
`ifdef ARQ_AUTOFLUSH_EN
        w_retx   = r_retx;
`endif
        if (i_ack) begin
            w_wait = 1'b0;
`ifdef ARQ_AUTOFLUSH_EN
            w_retx = 4'd0;
`endif
            if (r_pend_v) begin
                w_sel    = ~r_sel;
                w_act_v  = 1'b1;
                w_pend_v = 1'b0;
            end else begin
                w_act_v = 1'b0;
            end
        end
        if (i_dec) begin
            unique case (i_kind)
                KIND_ZERO: begin
                    w_seqn  = ~r_seqn;
                    w_wait  = 1'b1;
                    w_act_v = 1'b0;
                    w_flush = 1'b0;
`ifdef ARQ_AUTOFLUSH_EN
                    w_retx  = 4'd0;
`endif
                end
                KIND_OLD: begin
`ifdef ARQ_AUTOFLUSH_EN
                    if (r_retx != 4'hF) w_retx = r_retx + 4'd1;
                    if (w_retx == 4'(RETX_MAX)) w_flush = 1'b1;
`endif
                end
                KIND_NEW: begin
                    w_seqn = ~r_seqn;
                    w_wait = 1'b1;
`ifdef ARQ_AUTOFLUSH_EN
                    w_retx = 4'd0;
`endif
                end
                KIND_NULL: ;
            endcase
        end
        w_full = w_act_v & w_pend_v;
        if (i_load) begin
            if (!w_act_v) begin
                w_act_v      = 1'b1;
                w_len[w_sel] = i_load_len;
            end else if (!w_pend_v) begin
                w_pend_v      = 1'b1;
                w_len[~w_sel] = i_load_len;
            end
        end
        if (i_flush && (r_act_v || r_wait)) w_flush = 1'b1;
    end

    // State registers; new connection clears like reset.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_act_v  <= 1'b0;
            r_pend_v <= 1'b0;
            r_sel    <= 1'b0;
            r_seqn   <= 1'b0;
            r_wait   <= 1'b0;
            r_flush  <= 1'b0;
            r_len[0] <= '0;
            r_len[1] <= '0;
`ifdef ARQ_AUTOFLUSH_EN
            r_retx   <= 4'd0;
`endif
        end else if (i_init) begin
            r_act_v  <= 1'b0;
            r_pend_v <= 1'b0;
            r_sel    <= 1'b0;
            r_seqn   <= 1'b0;
            r_wait   <= 1'b0;
            r_flush  <= 1'b0;
            r_len[0] <= '0;
            r_len[1] <= '0;
`ifdef ARQ_AUTOFLUSH_EN
            r_retx   <= 4'd0;
`endif
        end else begin
            r_act_v  <= w_act_v;
            r_pend_v <= w_pend_v;
            r_sel    <= w_sel;
            r_seqn   <= w_seqn;
            r_wait   <= w_wait;
            r_flush  <= w_flush;
            r_len[0] <= w_len[0];
            r_len[1] <= w_len[1];
`ifdef ARQ_AUTOFLUSH_EN
            r_retx   <= w_retx;
`endif
        end
    end

    assign o_act_v    = r_act_v;
    assign o_pend_v   = r_pend_v;
    assign o_act_sel  = r_sel;
    assign o_seqn     = r_seqn;
    assign o_wait_ack = r_wait;
    assign o_flush_f  = r_flush;
    assign o_full     = w_full;
    assign o_len_act  = r_len[r_sel];

endmodule

// File: rtl/acltx_arqsrc.sv
// ACL TX ARQ source: per-slot NULL/NEW/OLD/ZERO decision engine.
// Define ARQ_AUTOFLUSH_EN to flush after RETX_MAX retransmissions.
module acltx_arqsrc
    import arq_pkg::*;
#(
    parameter int NUM_LT   = 8,
    parameter int LEN_W    = 10,
    parameter int RETX_MAX = 15
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              conns_start_p,
    input  logic              mcu_load_p,
    input  logic [LT_W-1:0]   mcu_load_lt,
    input  logic [LEN_W-1:0]  mcu_load_len,
    input  logic              mcu_flush_p,
    input  logic              tx_req_p,
    input  logic [LT_W-1:0]   tx_lt,
    input  logic [NUM_LT-1:0] rx_arqn,
    input  logic [NUM_LT-1:0] rx_flow,
    output logic              tx_vld_p,
    output logic [1:0]        tx_kind,
    output logic              tx_seqn,
    output logic              tx_bufsel,
    output logic [LEN_W-1:0]  tx_len,
    output logic [NUM_LT-1:0] buf_avail,
    output logic              ack_free_p,
    output logic [LT_W-1:0]   ack_lt,
    output logic              load_err_p,
    output logic              busy
);

    if (RETX_MAX < 1 || RETX_MAX > 15) begin : g_bad_retx
        $error("RETX_MAX must fit the 4-bit retransmit counter");
    end

    state_e            r_state, w_state_nxt;
    logic [LT_W-1:0]   r_lt, w_lt_nxt;
    kind_e             r_kind, w_kind;
    logic              r_seqn, r_bufsel;
    logic [LEN_W-1:0]  r_len;
    logic              w_ack_en, w_dec_en;
    logic              w_seqn, w_ack_free;
    logic [LEN_W-1:0]  w_len;

    logic [NUM_LT-1:0] w_act_v, w_pend_v, w_sel, w_seqn_lt;
    logic [NUM_LT-1:0] w_wait, w_flush, w_full;
    logic [LEN_W-1:0]  w_len_act [NUM_LT];

    for (genvar g = 0; g < NUM_LT; g++) begin : g_lt
        acltx_ltstate #(
            .LEN_W      (LEN_W)
`ifdef ARQ_AUTOFLUSH_EN
           ,.RETX_MAX   (RETX_MAX)
`endif
        ) u_lt (
            .clk_6M     (clk_6M),
            .rstz       (rstz),
            .i_init     (conns_start_p),
            .i_ack      (w_ack_en && r_lt == LT_W'(g)),
            .i_dec      (w_dec_en && r_lt == LT_W'(g)),
            .i_kind     (w_kind),
            .i_load     (mcu_load_p && mcu_load_lt == LT_W'(g)),
            .i_load_len (mcu_load_len),
            .i_flush    (mcu_flush_p && mcu_load_lt == LT_W'(g)),
            .o_act_v    (w_act_v[g]),
            .o_pend_v   (w_pend_v[g]),
            .o_act_sel  (w_sel[g]),
            .o_seqn     (w_seqn_lt[g]),
            .o_wait_ack (w_wait[g]),
            .o_flush_f  (w_flush[g]),
            .o_full     (w_full[g]),
            .o_len_act  (w_len_act[g])
        );
    end

    // Slot decision for the latched LT, in priority order.
    always_comb begin
        w_kind = KIND_NULL;
        priority case (1'b1)
            !rx_flow[r_lt]:  w_kind = KIND_NULL;
            w_flush[r_lt]:   w_kind = KIND_ZERO;
            w_wait[r_lt]:    w_kind = KIND_OLD;
            w_act_v[r_lt]:   w_kind = KIND_NEW;
            default:         w_kind = KIND_NULL;
        endcase
        w_seqn = w_seqn_lt[r_lt];
        if (w_kind == KIND_NEW || w_kind == KIND_ZERO)
            w_seqn = ~w_seqn_lt[r_lt];
        w_len = '0;
        if (w_kind == KIND_NEW || w_kind == KIND_OLD)
            w_len = w_len_act[r_lt];
    end

    // FSM state register and latched LT.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state <= ST_IDLE;
            r_lt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lt    <= w_lt_nxt;
        end
    end

    // FSM next state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_lt_nxt    = r_lt;
        w_ack_en    = 1'b0;
        w_dec_en    = 1'b0;
        w_ack_free  = 1'b0;
        if (conns_start_p) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (tx_req_p) begin
                        w_state_nxt = ST_ACKCHK;
                        w_lt_nxt    = tx_lt;
                    end
                end
                ST_ACKCHK: begin
                    w_state_nxt = ST_DECIDE;
                    if (w_wait[r_lt] && rx_arqn[r_lt]) begin
                        w_ack_en   = 1'b1;
                        w_ack_free = w_act_v[r_lt];
                    end
                end
                ST_DECIDE: begin
                    w_state_nxt = ST_IDLE;
                    w_dec_en    = 1'b1;
                    w_ack_free  = (w_kind == KIND_ZERO) && w_act_v[r_lt];
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Hold the last decision between strobes.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_kind   <= KIND_NULL;
            r_seqn   <= 1'b0;
            r_bufsel <= 1'b0;
            r_len    <= '0;
        end else if (conns_start_p) begin
            r_kind   <= KIND_NULL;
            r_seqn   <= 1'b0;
            r_bufsel <= 1'b0;
            r_len    <= '0;
        end else if (w_dec_en) begin
            r_kind   <= w_kind;
            r_seqn   <= w_seqn;
            r_bufsel <= w_sel[r_lt];
            r_len    <= w_len;
        end
    end

    assign tx_vld_p   = w_dec_en;
    assign tx_kind    = w_dec_en ? w_kind : r_kind;
    assign tx_seqn    = w_dec_en ? w_seqn : r_seqn;
    assign tx_bufsel  = w_dec_en ? w_sel[r_lt] : r_bufsel;
    assign tx_len     = w_dec_en ? w_len : r_len;
    assign buf_avail  = ~(w_act_v & w_pend_v);
    assign ack_free_p = w_ack_free;
    assign ack_lt     = w_ack_free ? r_lt : '0;
    assign load_err_p = mcu_load_p && !conns_start_p && w_full[mcu_load_lt];
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_acltx_arqsrc.sv
// Directed bench for acltx_arqsrc with hand-computed expectations.
// Autoflush steps run only when ARQ_AUTOFLUSH_EN is defined.
module tb_acltx_arqsrc;

    logic       clk_6M = 1'b0;
    logic       rstz;
    logic       conns_start_p;
    logic       mcu_load_p;
    logic [2:0] mcu_load_lt;
    logic [9:0] mcu_load_len;
    logic       mcu_flush_p;
    logic       tx_req_p;
    logic [2:0] tx_lt;
    logic [7:0] rx_arqn;
    logic [7:0] rx_flow;
    logic       tx_vld_p;
    logic [1:0] tx_kind;
    logic       tx_seqn;
    logic       tx_bufsel;
    logic [9:0] tx_len;
    logic [7:0] buf_avail;
    logic       ack_free_p;
    logic [2:0] ack_lt;
    logic       load_err_p;
    logic       busy;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] K_NULL = 2'd0;
    localparam logic [1:0] K_NEW  = 2'd1;
    localparam logic [1:0] K_OLD  = 2'd2;
    localparam logic [1:0] K_ZERO = 2'd3;

    acltx_arqsrc #(
        .NUM_LT   (8),
        .LEN_W    (10),
        .RETX_MAX (3)
    ) dut (
        .clk_6M        (clk_6M),
        .rstz          (rstz),
        .conns_start_p (conns_start_p),
        .mcu_load_p    (mcu_load_p),
        .mcu_load_lt   (mcu_load_lt),
        .mcu_load_len  (mcu_load_len),
        .mcu_flush_p   (mcu_flush_p),
        .tx_req_p      (tx_req_p),
        .tx_lt         (tx_lt),
        .rx_arqn       (rx_arqn),
        .rx_flow       (rx_flow),
        .tx_vld_p      (tx_vld_p),
        .tx_kind       (tx_kind),
        .tx_seqn       (tx_seqn),
        .tx_bufsel     (tx_bufsel),
        .tx_len        (tx_len),
        .buf_avail     (buf_avail),
        .ack_free_p    (ack_free_p),
        .ack_lt        (ack_lt),
        .load_err_p    (load_err_p),
        .busy          (busy)
    );

    always #83 clk_6M = ~clk_6M;

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] lt, input logic [9:0] len);
        mcu_load_p   = 1'b1;
        mcu_load_lt  = lt;
        mcu_load_len = len;
        tick();
        mcu_load_p   = 1'b0;
    endtask

    // One full slot: request, ACKCHK cycle, DECIDE cycle, back to IDLE.
    task automatic slot(input string tag,
                        input logic [2:0] lt,
                        input logic [1:0] k,
                        input logic       s,
                        input logic       b,
                        input logic [9:0] l,
                        input logic       ack_a,
                        input logic       ack_d);
        tx_req_p = 1'b1;
        tx_lt    = lt;
        tick();
        tx_req_p = 1'b0;
        chk({tag, "_a_vld"},  32'(tx_vld_p), 32'd0);
        chk({tag, "_a_busy"}, 32'(busy), 32'd1);
        chk({tag, "_a_free"}, 32'(ack_free_p), 32'(ack_a));
        chk({tag, "_a_ltid"}, 32'(ack_lt), ack_a ? 32'(lt) : 32'd0);
        tick();
        chk({tag, "_d_vld"},  32'(tx_vld_p), 32'd1);
        chk({tag, "_d_kind"}, 32'(tx_kind), 32'(k));
        chk({tag, "_d_seqn"}, 32'(tx_seqn), 32'(s));
        chk({tag, "_d_bsel"}, 32'(tx_bufsel), 32'(b));
        chk({tag, "_d_len"},  32'(tx_len), 32'(l));
        chk({tag, "_d_free"}, 32'(ack_free_p), 32'(ack_d));
        chk({tag, "_d_ltid"}, 32'(ack_lt), ack_d ? 32'(lt) : 32'd0);
        tick();
        chk({tag, "_i_vld"},  32'(tx_vld_p), 32'd0);
        chk({tag, "_i_busy"}, 32'(busy), 32'd0);
        chk({tag, "_i_kind"}, 32'(tx_kind), 32'(k));
        chk({tag, "_i_len"},  32'(tx_len), 32'(l));
    endtask

    initial begin
        rstz          = 1'b0;
        conns_start_p = 1'b0;
        mcu_load_p    = 1'b0;
        mcu_load_lt   = 3'd0;
        mcu_load_len  = 10'd0;
        mcu_flush_p   = 1'b0;
        tx_req_p      = 1'b0;
        tx_lt         = 3'd0;
        rx_arqn       = 8'h00;
        rx_flow       = 8'hFF;
        repeat (2) tick();
        chk("rst_avail", 32'(buf_avail), 32'hFF);
        chk("rst_vld",   32'(tx_vld_p), 32'd0);
        chk("rst_kind",  32'(tx_kind), 32'd0);
        chk("rst_seqn",  32'(tx_seqn), 32'd0);
        chk("rst_len",   32'(tx_len), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_free",  32'(ack_free_p), 32'd0);
        chk("rst_lerr",  32'(load_err_p), 32'd0);
        rstz = 1'b1;
        tick();

        // LT1: NEW, NAK -> OLD, ACK -> free then NULL
        load(3'd1, 10'd27);
        chk("lt1_avail", 32'(buf_avail), 32'hFF);
        slot("lt1_new", 3'd1, K_NEW, 1'b1, 1'b0, 10'd27, 1'b0, 1'b0);
        slot("lt1_old", 3'd1, K_OLD, 1'b1, 1'b0, 10'd27, 1'b0, 1'b0);
        rx_arqn = 8'h02;
        slot("lt1_ack", 3'd1, K_NULL, 1'b1, 1'b0, 10'd0, 1'b1, 1'b0);
        rx_arqn = 8'h00;

        // LT2: fill both buffers, overflow, then ping-pong
        load(3'd2, 10'd10);
        load(3'd2, 10'd20);
        chk("lt2_avail", 32'(buf_avail), 32'hFB);
        mcu_load_p   = 1'b1;
        mcu_load_lt  = 3'd2;
        mcu_load_len = 10'd30;
        #1;
        chk("lt2_lerr", 32'(load_err_p), 32'd1);
        tick();
        mcu_load_p = 1'b0;
        #1;
        chk("lt2_lerr_off", 32'(load_err_p), 32'd0);
        slot("lt2_new0", 3'd2, K_NEW, 1'b1, 1'b0, 10'd10, 1'b0, 1'b0);
        chk("lt2_avail2", 32'(buf_avail), 32'hFB);
        rx_arqn = 8'h04;
        slot("lt2_new1", 3'd2, K_NEW, 1'b0, 1'b1, 10'd20, 1'b1, 1'b0);
        rx_arqn = 8'h00;
        chk("lt2_avail3", 32'(buf_avail), 32'hFF);

        // LT3: flow stop holds, flow resumes -> OLD
        load(3'd3, 10'd5);
        slot("lt3_new", 3'd3, K_NEW, 1'b1, 1'b0, 10'd5, 1'b0, 1'b0);
        rx_flow = 8'hF7;
        slot("lt3_stop", 3'd3, K_NULL, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        rx_flow = 8'hFF;
        slot("lt3_old", 3'd3, K_OLD, 1'b1, 1'b0, 10'd5, 1'b0, 1'b0);

        // LT4: flush while awaiting ack -> ZERO
        load(3'd4, 10'd7);
        slot("lt4_new", 3'd4, K_NEW, 1'b1, 1'b0, 10'd7, 1'b0, 1'b0);
        mcu_flush_p = 1'b1;
        mcu_load_lt = 3'd4;
        tick();
        mcu_flush_p = 1'b0;
        slot("lt4_zero", 3'd4, K_ZERO, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1);

        // LT5: flush of an idle LT is ignored
        mcu_flush_p = 1'b1;
        mcu_load_lt = 3'd5;
        tick();
        mcu_flush_p = 1'b0;
        slot("lt5_null", 3'd5, K_NULL, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);

        // Request held high while busy starts no second slot
        tx_req_p = 1'b1;
        tx_lt    = 3'd6;
        tick();
        chk("bz_ack_busy", 32'(busy), 32'd1);
        tick();
        chk("bz_dec_vld", 32'(tx_vld_p), 32'd1);
        tx_req_p = 1'b0;
        tick();
        chk("bz_idle_busy", 32'(busy), 32'd0);
        chk("bz_idle_vld",  32'(tx_vld_p), 32'd0);

`ifdef ARQ_AUTOFLUSH_EN
        // LT7: three NAKed retransmits reach RETX_MAX=3 -> ZERO
        load(3'd7, 10'd4);
        slot("af_new",  3'd7, K_NEW, 1'b1, 1'b0, 10'd4, 1'b0, 1'b0);
        slot("af_old1", 3'd7, K_OLD, 1'b1, 1'b0, 10'd4, 1'b0, 1'b0);
        slot("af_old2", 3'd7, K_OLD, 1'b1, 1'b0, 10'd4, 1'b0, 1'b0);
        slot("af_old3", 3'd7, K_OLD, 1'b1, 1'b0, 10'd4, 1'b0, 1'b0);
        slot("af_zero", 3'd7, K_ZERO, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
`endif

        // New connection mid-slot clears everything
        load(3'd1, 10'd9);
        load(3'd2, 10'd11);
        chk("cs_avail_pre", 32'(buf_avail), 32'hFB);
        tx_req_p = 1'b1;
        tx_lt    = 3'd1;
        tick();
        tx_req_p      = 1'b0;
        conns_start_p = 1'b1;
        tick();
        conns_start_p = 1'b0;
        chk("cs_busy",  32'(busy), 32'd0);
        chk("cs_avail", 32'(buf_avail), 32'hFF);
        chk("cs_kind",  32'(tx_kind), 32'd0);
        tick();
        chk("cs_novld", 32'(tx_vld_p), 32'd0);
        load(3'd1, 10'd12);
        slot("cs_new", 3'd1, K_NEW, 1'b1, 1'b0, 10'd12, 1'b0, 1'b0);

        // Async reset in the middle of a decision
        tx_req_p = 1'b1;
        tx_lt    = 3'd2;
        tick();
        tx_req_p = 1'b0;
        rstz     = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_vld",  32'(tx_vld_p), 32'd0);
        tick();
        chk("ar_vld2", 32'(tx_vld_p), 32'd0);
        chk("ar_kind", 32'(tx_kind), 32'd0);
        rstz = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acltx_arqsrc.md
Name: acltx_arqsrc

Overview:
- Source-side ARQ engine for ACL links; it is the transmit counterpart to the RX ARQN/SEQN_old logic.
- Per LT_ADDR it owns a two-entry (ping-pong) payload buffer status and decides at each TX slot between NULL, NEW, OLD (retransmit) or ZERO (zero-length flush continuation).
- It drives the packet encoder with SEQN, buffer select and length, and tells the MCU when a buffer has been acknowledged and freed.

Parameters:
- NUM_LT, 8, number of logical transports tracked (index width 3)
- LEN_W, 10, payload length field width
- RETX_MAX, 15, retransmission count that triggers auto-flush (used only with ARQ_AUTOFLUSH_EN)

Ports:
- clk_6M  in  1  clock
- rstz  in  1  reset
- conns_start_p  in  1  new connection; reinitialises all LT state
- mcu_load_p  in  1  MCU has written one payload buffer
- mcu_load_lt  in  3  LT_ADDR of loaded payload
- mcu_load_len  in  LEN_W  payload byte length
- mcu_flush_p  in  1  MCU flush request for mcu_load_lt
- tx_req_p  in  1  encoder requests a decision for the coming TX slot
- tx_lt  in  3  LT_ADDR of the TX slot
- rx_arqn  in  NUM_LT  latest decoded ARQN per LT (1=ACK)
- rx_flow  in  NUM_LT  latest decoded FLOW per LT (1=GO)
- tx_vld_p  out  1  decision valid strobe
- tx_kind  out  2  0=NULL 1=NEW 2=OLD 3=ZERO
- tx_seqn  out  1  SEQN to put in header
- tx_bufsel  out  1  buffer index to read payload from
- tx_len  out  LEN_W  payload length (0 for NULL/ZERO)
- buf_avail  out  NUM_LT  1 = LT can accept another load
- ack_free_p  out  1  active buffer of ack_lt released
- ack_lt  out  3  LT released
- load_err_p  out  1  load into full LT, dropped
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (rstz low, asynchronous) or conns_start_p:
  - all per-LT valid, wait_ack, flush and retx_cnt cleared; seqn=0; bufsel=0
  - all outputs 0, except buf_avail=all ones
  - rstz low mid-decision aborts with no strobe.
- Per-LT state: act_v, pend_v, act_sel, len[2], seqn, wait_ack, flush_f, retx_cnt[3:0].
- FSM states IDLE, ACKCHK, DECIDE, with fixed latency:
  - tx_req_p in IDLE: move to ACKCHK and latch tx_lt.
  - ACKCHK -> DECIDE -> IDLE.
  - tx_vld_p pulses in the DECIDE cycle, 2 cycles after tx_req_p.
  - tx_req_p while busy is ignored.
- ACKCHK, if wait_ack and rx_arqn[lt]=1:
  - wait_ack=0, retx_cnt=0.
  - If act_v was set: act_v=0, ack_free_p with ack_lt=lt.
  - If pend_v: the pending buffer becomes active (act_sel flips, act_v=1, pend_v=0).
- DECIDE, priority order:
  1. rx_flow[lt]=0 -> NULL. State unchanged; wait_ack held so the old payload is resent after flow resumes.
  2. flush_f -> ZERO:
     - seqn toggles; wait_ack=1
     - act_v=0 with ack_free_p
     - flush_f=0; retx_cnt=0
  3. wait_ack -> OLD: same seqn, same bufsel/len; retx_cnt saturating +1.
  4. act_v -> NEW: seqn toggles, then is driven; wait_ack=1; retx_cnt=0.
  5. else NULL.
- tx_seqn/tx_bufsel/tx_len hold until the next tx_vld_p.
- MCU load:
  - Target is the active slot if act_v=0, else the pending slot if pend_v=0, else load_err_p.
  - Occupancy is evaluated after the same-cycle ACKCHK release for that LT.
  - buf_avail[i] = !(act_v & pend_v).
- mcu_flush_p sets flush_f[lt] only if act_v or wait_ack; otherwise ignored. Flush in the same cycle as DECIDE for the same LT takes effect next slot.
- First NEW after reset sends SEQN=1.

Optional Feature:
- ARQ_AUTOFLUSH_EN defined: in DECIDE, an OLD decision that brings retx_cnt to RETX_MAX also sets flush_f, so the next non-flow-stopped slot sends ZERO.
- Not defined: retransmission is unlimited, retx_cnt is not implemented, and RETX_MAX is unused.

Decomposition:
- Package arq_pkg holds:
  - tx_kind encodings (KIND_NULL/NEW/OLD/ZERO)
  - FSM state encodings
  - the LT width constant
- One natural sub-module, acltx_ltstate: a per-LT state slice, instantiated NUM_LT times, holding the valid/seqn/retx registers with update enables from the FSM.

Test Plan:
- Load LT1 len 27, tx_req_p lt=1 with rx_flow=ff -> tx_vld_p at +2, kind NEW, seqn 1, bufsel 0, len 27.
- Repeat slot with rx_arqn[1]=0 -> kind OLD, seqn 1, len 27. Then rx_arqn[1]=1 -> ack_free_p with ack_lt=1, then kind NULL.
- Two loads LT2 (len 10, 20) then a third -> load_err_p, buf_avail[2]=0.
  - NEW len 10; after ACK, NEW len 20, seqn toggled, bufsel 1.
- rx_flow[3]=0 with LT3 awaiting ack -> NULL. Flow back with arqn NAK -> OLD with same seqn.
- mcu_flush_p on LT4 while awaiting ack -> next slot ZERO, len 0, seqn toggled, ack_free_p.
  - With ARQ_AUTOFLUSH_EN and RETX_MAX=3: three NAKs then ZERO.
- conns_start_p mid-traffic -> all state cleared, buf_avail=ff; next NEW sends seqn 1.
